dcache_ctrl: RTL and testbench

Direct-mapped, write-back, write-allocate data cache with its miss-handling state machine. It sits between the memory stage and the unified backing memory: it services loads and stores from the exmem register, drives the pipeline-wide `Dmem_Stall` freeze while a miss is outstanding, and fills or evicts 4-word lines over a req/ack memory port.

---
 rtl/dcache_ctrl_pkg.sv | 22 ++
 rtl/dcache_ctrl_if.sv | 37 +++
 rtl/dcache_array.sv | 59 +++++
 rtl/dcache_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/dcache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl_pkg
//  Description : Shared field widths and state encoding for the data cache.
//  Revision    : 1.0 - initial release
// ============================================================================
package dcache_ctrl_pkg;

  localparam int c_TAG_W  = 8;   // Addr[15:8]
  localparam int c_IDX_W  = 5;   // Addr[7:3]
  localparam int c_OFF_W  = 2;   // Addr[2:1]
  localparam int c_WORD_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EVICT = 2'd1,
    ST_FILL  = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/dcache_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl_if
//  Description : Pipeline-side and backing-memory-side signals of the cache.
//                slave = cache controller, master = pipeline plus memory.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dcache_ctrl_if;
  logic [15:0] Addr;
  logic [15:0] DataIn;
  logic        Rd;
  logic        Wr;
  logic [15:0] DataOut;
  logic        Done;
  logic        Stall;
  logic        CacheHit;
  logic        err;
  logic        mem_req;
  logic        mem_wr;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ack;

  modport slave (
    input  Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    output DataOut, Done, Stall, CacheHit, err,
    output mem_req, mem_wr, mem_addr, mem_wdata
  );

  modport master (
    output Addr, DataIn, Rd, Wr, mem_rdata, mem_ack,
    input  DataOut, Done, Stall, CacheHit, err,
    input  mem_req, mem_wr, mem_addr, mem_wdata
  );
endinterface
`default_nettype wire

// File: rtl/dcache_array.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_array
//  Description : Line storage: valid, dirty, tag and WORDS x 16-bit data.
//                Asynchronous read by index, synchronous word write and
//                metadata update. Reset clears only valid and dirty.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_array
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES = 32,
  parameter int WORDS = 4
) (
  input  wire logic                             clk,
  input  wire logic                             rst,
  input  wire logic [c_IDX_W-1:0]               idx,
  output logic                                  rd_valid,
  output logic                                  rd_dirty,
  output logic [c_TAG_W-1:0]                    rd_tag,
  output logic [WORDS-1:0][c_WORD_W-1:0]        rd_data,
  input  wire logic                             wr_en,
  input  wire logic [c_OFF_W-1:0]               wr_off,
  input  wire logic [c_WORD_W-1:0]              wr_data,
  input  wire logic                             meta_en,
  input  wire logic                             meta_valid,
  input  wire logic                             meta_dirty,
  input  wire logic [c_TAG_W-1:0]               meta_tag
);

  logic [LINES-1:0]                  r_valid;
  logic [LINES-1:0]                  r_dirty;
  logic [c_TAG_W-1:0]                r_tag  [LINES];
  logic [WORDS-1:0][c_WORD_W-1:0]    r_data [LINES];

  assign rd_valid = r_valid[idx];
  assign rd_dirty = r_dirty[idx];
  assign rd_tag   = r_tag[idx];
  assign rd_data  = r_data[idx];

  // Line state bits; the only storage that reset touches
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (meta_en) begin
      r_valid[idx] <= meta_valid;
      r_dirty[idx] <= meta_dirty;
    end
  end

  // Tag and data storage, left uninitialised across reset
  always_ff @(posedge clk) begin
    if (meta_en) r_tag[idx] <= meta_tag;
    if (wr_en)   r_data[idx][wr_off] <= wr_data;
  end

endmodule
`default_nettype wire

// File: rtl/dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : dcache_ctrl
//  Description : Direct-mapped write-back write-allocate data cache with
//                miss FSM (IDLE/EVICT/FILL/RESP), pipeline stall and
//                req/ack backing-memory port for 4-word line transfers.
//  Revision    : 1.0 - initial release
// ============================================================================
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int LINES = 32,
  parameter int WORDS = 4
) (
  input  wire logic   clk,
  input  wire logic   rst,
  dcache_ctrl_if.slave bus
);

  state_t                          r_state;
  logic [c_OFF_W-1:0]              r_cnt;

  logic [c_TAG_W-1:0]              w_tag;
  logic [c_IDX_W-1:0]              w_idx;
  logic [c_OFF_W-1:0]              w_off;
  logic                            w_req;
  logic                            w_hit;
  logic                            w_last;
  logic                            w_line_valid;
  logic                            w_line_dirty;
  logic [c_TAG_W-1:0]              w_line_tag;
  logic [WORDS-1:0][c_WORD_W-1:0]  w_line_data;

  logic                            w_wr_en;
  logic [c_OFF_W-1:0]              w_wr_off;
  logic [c_WORD_W-1:0]             w_wr_data;
  logic                            w_meta_en;
  logic                            w_meta_valid;
  logic                            w_meta_dirty;
  logic [c_TAG_W-1:0]              w_meta_tag;

  logic [15:0]                     w_dout;
  logic                            w_done;
  logic                            w_stall;
  logic                            w_cache_hit;
  logic                            w_mem_req;
  logic                            w_mem_wr;
  logic [15:0]                     w_mem_addr;
  logic [15:0]                     w_mem_wdata;

  // Address bit 0 is ignored for the access itself; it only raises err.
  assign w_tag  = bus.Addr[15:16-c_TAG_W];
  assign w_idx  = bus.Addr[3 +: c_IDX_W];
  assign w_off  = bus.Addr[2:1];
  assign w_req  = bus.Rd ^ bus.Wr;
  assign w_hit  = w_line_valid && (w_line_tag == w_tag);
  assign w_last = (r_cnt == 2'd3);

  dcache_array #(.LINES(LINES), .WORDS(WORDS)) u_array (
    .clk        (clk),
    .rst        (rst),
    .idx        (w_idx),
    .rd_valid   (w_line_valid),
    .rd_dirty   (w_line_dirty),
    .rd_tag     (w_line_tag),
    .rd_data    (w_line_data),
    .wr_en      (w_wr_en),
    .wr_off     (w_wr_off),
    .wr_data    (w_wr_data),
    .meta_en    (w_meta_en),
    .meta_valid (w_meta_valid),
    .meta_dirty (w_meta_dirty),
    .meta_tag   (w_meta_tag)
  );

  // Per-state outputs and array write controls; everything is forced low in reset
  always_comb begin
    w_wr_en      = 1'b0;
    w_wr_off     = w_off;
    w_wr_data    = bus.DataIn;
    w_meta_en    = 1'b0;
    w_meta_valid = w_line_valid;
    w_meta_dirty = w_line_dirty;
    w_meta_tag   = w_line_tag;
    w_dout       = '0;
    w_done       = 1'b0;
    w_stall      = 1'b0;
    w_cache_hit  = 1'b0;
    w_mem_req    = 1'b0;
    w_mem_wr     = 1'b0;
    w_mem_addr   = '0;
    w_mem_wdata  = '0;
    if (rst) begin
      case (r_state)
        ST_IDLE: begin
          if (w_req) begin
            if (w_hit) begin
              w_done      = 1'b1;
              w_cache_hit = 1'b1;
              if (bus.Rd) begin
                w_dout = w_line_data[w_off];
              end else begin
                w_wr_en      = 1'b1;
                w_meta_en    = 1'b1;
                w_meta_valid = 1'b1;
                w_meta_dirty = 1'b1;
              end
            end else begin
              w_stall = 1'b1;
            end
          end
        end
        ST_EVICT: begin
          w_stall     = 1'b1;
          w_mem_req   = 1'b1;
          w_mem_wr    = 1'b1;
          w_mem_addr  = {w_line_tag, w_idx, r_cnt, 1'b0};
          w_mem_wdata = w_line_data[r_cnt];
        end
        ST_FILL: begin
          w_stall    = 1'b1;
          w_mem_req  = 1'b1;
          w_mem_addr = {w_tag, w_idx, r_cnt, 1'b0};
          if (bus.mem_ack) begin
            // A store miss merges its word as that word arrives.
            w_wr_en   = 1'b1;
            w_wr_off  = r_cnt;
            w_wr_data = (bus.Wr && (r_cnt == w_off)) ? bus.DataIn : bus.mem_rdata;
            if (w_last) begin
              w_meta_en    = 1'b1;
              w_meta_valid = 1'b1;
              w_meta_dirty = bus.Wr;
              w_meta_tag   = w_tag;
            end
          end
        end
        ST_RESP: begin
          w_done = 1'b1;
          w_dout = w_line_data[w_off];
        end
        default: ;
      endcase
    end
  end

  assign bus.DataOut   = w_dout;
  assign bus.Done      = w_done;
  assign bus.Stall     = w_stall;
  assign bus.CacheHit  = w_cache_hit;
  assign bus.err       = rst && ((bus.Rd && bus.Wr) || (w_req && bus.Addr[0]));
  assign bus.mem_req   = w_mem_req;
  assign bus.mem_wr    = w_mem_wr;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

  // Miss FSM and line word counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_req && !w_hit) begin
            r_cnt   <= '0;
            r_state <= (w_line_valid && w_line_dirty) ? ST_EVICT : ST_FILL;
          end
        end
        ST_EVICT: begin
          if (bus.mem_ack) begin
            r_cnt <= r_cnt + 2'd1;
            if (w_last) r_state <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (bus.mem_ack) begin
            r_cnt <= r_cnt + 2'd1;
            if (w_last) r_state <= ST_RESP;
          end
        end
        ST_RESP: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dcache_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dcache_ctrl
//  Description : Directed self-checking bench for dcache_ctrl with a simple
//                backing-memory responder (configurable ack spacing).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dcache_ctrl;

  logic clk;
  logic rst;
  dcache_ctrl_if bus ();

  dcache_ctrl #(.LINES(32), .WORDS(4)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Backing memory: read data is fill_base + word offset; ack every ack_period req cycles
  int          ack_period = 1;
  int          wait_cnt   = 0;
  logic [15:0] fill_base  = 16'h0000;

  assign bus.mem_ack   = bus.mem_req && (wait_cnt >= ack_period - 1);
  assign bus.mem_rdata = fill_base + {14'd0, bus.mem_addr[2:1]};

  always @(posedge clk) begin
    if (!bus.mem_req || bus.mem_ack) wait_cnt <= 0;
    else                             wait_cnt <= wait_cnt + 1;
  end

  // Transfer log
  logic [15:0] ev_addr [64];
  logic [15:0] ev_data [64];
  logic [15:0] rd_addr [64];
  int ev_n = 0;
  int rd_n = 0;

  always @(posedge clk) begin
    if (rst && bus.mem_req && bus.mem_ack) begin
      if (bus.mem_wr) begin
        if (ev_n < 64) begin
          ev_addr[ev_n] <= bus.mem_addr;
          ev_data[ev_n] <= bus.mem_wdata;
        end
        ev_n <= ev_n + 1;
      end else begin
        if (rd_n < 64) rd_addr[rd_n] <= bus.mem_addr;
        rd_n <= rd_n + 1;
      end
    end
  end

  // Memory outputs must hold while a request waits for ack
  logic        mon_en    = 1'b0;
  logic        prev_wait = 1'b0;
  logic [15:0] prev_addr = '0;
  logic        prev_wr   = 1'b0;

  always @(negedge clk) begin
    if (mon_en && prev_wait && bus.mem_req) begin
      check("hold_addr", {16'd0, bus.mem_addr}, {16'd0, prev_addr});
      check("hold_wr", {31'd0, bus.mem_wr}, {31'd0, prev_wr});
    end
    prev_wait <= mon_en && bus.mem_req && !bus.mem_ack;
    prev_addr <= bus.mem_addr;
    prev_wr   <= bus.mem_wr;
  end

  int ev0;
  int rd0;

  // One access starting just after a posedge; lat = cycles until Done
  task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, output int lat,
                        output logic [15:0] dout, output logic hit, output logic er);
    bit seen;
    seen = 1'b0;
    lat  = 0;
    dout = '0;
    hit  = 1'b0;
    er   = 1'b0;
    ev0  = ev_n;
    rd0  = rd_n;
    bus.Rd = rd; bus.Wr = wr; bus.Addr = a; bus.DataIn = d;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        dout = bus.DataOut;
        hit  = bus.CacheHit;
        er   = bus.err;
        seen = 1'b1;
        break;
      end
      lat++;
      @(posedge clk); #1;
    end
    check("done_in_budget", {31'd0, seen}, 32'd1);
    @(posedge clk); #1;
    bus.Rd = 1'b0; bus.Wr = 1'b0;
  endtask

  int          lat;
  logic [15:0] dout;
  logic        hit;
  logic        er;

  initial begin
    rst = 1'b0;
    bus.Rd = 1'b0; bus.Wr = 1'b0; bus.Addr = '0; bus.DataIn = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_req", {31'd0, bus.mem_req}, 32'd0);
    check("rst_stall", {31'd0, bus.Stall}, 32'd0);
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check("idle_outs", {bus.Done, bus.Stall, bus.CacheHit, bus.err, bus.mem_req, bus.DataOut},
          21'd0);
    @(posedge clk); #1;

    // Cold read
    fill_base = 16'hA000;
    access(1, 0, 16'h1234, 16'h0, lat, dout, hit, er);
    check("cold_lat", lat, 5);
    check("cold_data", {16'd0, dout}, 32'h0000A002);
    check("cold_hit", {31'd0, hit}, 32'd0);
    check("cold_rd0", {16'd0, rd_addr[rd0]}, 32'h00001230);
    check("cold_rd3", {16'd0, rd_addr[rd0+3]}, 32'h00001236);

    // Repeat read hits
    access(1, 0, 16'h1234, 16'h0, lat, dout, hit, er);
    check("hit_lat", lat, 0);
    check("hit_flag", {31'd0, hit}, 32'd1);
    check("hit_data", {16'd0, dout}, 32'h0000A002);

    // Odd address: err, same word
    access(1, 0, 16'h1235, 16'h0, lat, dout, hit, er);
    check("odd_err", {31'd0, er}, 32'd1);
    check("odd_data", {16'd0, dout}, 32'h0000A002);

    // Rd and Wr together
    bus.Rd = 1'b1; bus.Wr = 1'b1; bus.Addr = 16'h5534;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("both_err", {31'd0, bus.err}, 32'd1);
      check("both_done", {31'd0, bus.Done}, 32'd0);
      check("both_req", {31'd0, bus.mem_req}, 32'd0);
      @(posedge clk); #1;
    end
    bus.Rd = 1'b0; bus.Wr = 1'b0;
    access(1, 0, 16'h1234, 16'h0, lat, dout, hit, er);
    check("both_nochg_lat", lat, 0);

    // Write hit, then dirty eviction
    access(0, 1, 16'h1234, 16'hBEEF, lat, dout, hit, er);
    check("wrhit_lat", lat, 0);
    check("wrhit_flag", {31'd0, hit}, 32'd1);
    fill_base = 16'hB000;
    access(1, 0, 16'h5534, 16'h0, lat, dout, hit, er);
    check("dirty_lat", lat, 9);
    check("dirty_data", {16'd0, dout}, 32'h0000B002);
    check("dirty_evn", ev_n - ev0, 4);
    check("ev_a0", {16'd0, ev_addr[ev0]}, 32'h00001230);
    check("ev_d0", {16'd0, ev_data[ev0]}, 32'h0000A000);
    check("ev_a2", {16'd0, ev_addr[ev0+2]}, 32'h00001234);
    check("ev_d2", {16'd0, ev_data[ev0+2]}, 32'h0000BEEF);
    check("ev_d3", {16'd0, ev_data[ev0+3]}, 32'h0000A003);
    check("fill_a0", {16'd0, rd_addr[rd0]}, 32'h00005530);
    check("fill_a3", {16'd0, rd_addr[rd0+3]}, 32'h00005536);

    // Load miss left the line clean: conflict is a clean miss
    fill_base = 16'hC000;
    access(1, 0, 16'h1234, 16'h0, lat, dout, hit, er);
    check("clean_lat", lat, 5);
    check("clean_evn", ev_n - ev0, 0);
    check("clean_data", {16'd0, dout}, 32'h0000C002);

    // Store miss merge
    fill_base = 16'hE000;
    access(0, 1, 16'h2006, 16'h7777, lat, dout, hit, er);
    check("smiss_lat", lat, 5);
    check("smiss_hit", {31'd0, hit}, 32'd0);
    access(1, 0, 16'h2006, 16'h0, lat, dout, hit, er);
    check("smiss_rd_lat", lat, 0);
    check("smiss_rd_data", {16'd0, dout}, 32'h00007777);
    fill_base = 16'hD000;
    access(1, 0, 16'h3000, 16'h0, lat, dout, hit, er);
    check("smiss_evict_lat", lat, 9);
    check("smiss_ev_a0", {16'd0, ev_addr[ev0]}, 32'h00002000);
    check("smiss_ev_d0", {16'd0, ev_data[ev0]}, 32'h0000E000);
    check("smiss_ev_d3", {16'd0, ev_data[ev0+3]}, 32'h00007777);
    check("smiss_new", {16'd0, dout}, 32'h0000D000);

    // Wait states: ack every third cycle
    ack_period = 3;
    fill_base  = 16'h1100;
    mon_en     = 1'b1;
    access(1, 0, 16'h4810, 16'h0, lat, dout, hit, er);
    mon_en     = 1'b0;
    check("wait_lat", lat, 13);
    check("wait_data", {16'd0, dout}, 32'h00001100);
    ack_period = 1;

    // Reset during FILL at cnt=2
    fill_base = 16'h2200;
    bus.Addr = 16'h6018; bus.Rd = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    check("prerst_req", {31'd0, bus.mem_req}, 32'd1);
    check("prerst_addr", {16'd0, bus.mem_addr}, 32'h0000601C);
    rst = 1'b0;
    #1;
    check("midrst_req", {31'd0, bus.mem_req}, 32'd0);
    check("midrst_stall", {31'd0, bus.Stall}, 32'd0);
    check("midrst_done", {31'd0, bus.Done}, 32'd0);
    bus.Rd = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    access(1, 0, 16'h6018, 16'h0, lat, dout, hit, er);
    check("postrst_lat", lat, 5);
    check("postrst_data", {16'd0, dout}, 32'h00002200);
    access(1, 0, 16'h1234, 16'h0, lat, dout, hit, er);
    check("postrst_inval_lat", lat, 5);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
`default_nettype wire
